// File: rtl/st7735_spi_rx.sv
// ST7735 4-wire write-bus receiver: oversampled SPI deserializer plus
// CASET/RASET/RAMWR decoder producing a pixel stream with coordinates.
module st7735_spi_rx #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] X_MAX       = 8'd127,
    parameter logic [7:0] Y_MAX       = 8'd159
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        spi_cs,
    input  logic        spi_dc,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic [8:0]  rx_data,
    output logic        rx_valid,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pix_valid,
    output logic [15:0] pix_color,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CASET, S_RASET, S_RAMWR, S_OTHER
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_s, r_dc_s, r_sclk_s, r_mosi_s;
    logic                   w_cs, w_dc, w_sclk, w_mosi, w_rise;
    logic                   r_sclk_q;

    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;
    logic        r_done, r_dc_lat, r_ferr;

    state_t      r_state;
    logic [2:0]  r_pidx;
    logic        r_phase;
    logic [7:0]  r_hi;
    logic [7:0]  r_xs, r_xe, r_ys, r_ye, r_x, r_y;
    logic [8:0]  r_rx_data;
    logic        r_rx_valid, r_cmd_valid, r_pix_valid;
    logic [7:0]  r_cmd_code, r_pix_x, r_pix_y;
    logic [15:0] r_pix_color;

    assign w_cs   = r_cs_s[SYNC_STAGES-1];
    assign w_dc   = r_dc_s[SYNC_STAGES-1];
    assign w_sclk = r_sclk_s[SYNC_STAGES-1];
    assign w_mosi = r_mosi_s[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_q & ~w_cs;

    // CS resets to the deasserted level so the bus looks idle after reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cs_s   <= '1;
            r_dc_s   <= '0;
            r_sclk_s <= '0;
            r_mosi_s <= '0;
            r_sclk_q <= 1'b0;
        end else begin
            r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], spi_cs};
            r_dc_s   <= {r_dc_s[SYNC_STAGES-2:0], spi_dc};
            r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_q <= w_sclk;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
            r_dc_lat <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            if (w_cs) begin
                r_bitcnt <= '0;
                r_ferr   <= (r_bitcnt != 3'd0);
            end else if (w_rise) begin
                r_shift <= {r_shift[6:0], w_mosi};
                if (r_bitcnt == 3'd7) begin
                    r_bitcnt <= '0;
                    r_done   <= 1'b1;
                    r_dc_lat <= w_dc;
                end else begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_pidx      <= '0;
            r_phase     <= 1'b0;
            r_hi        <= '0;
            r_xs        <= '0;
            r_xe        <= X_MAX;
            r_ys        <= '0;
            r_ye        <= Y_MAX;
            r_x         <= '0;
            r_y         <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_color <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_pix_valid <= 1'b0;
            if (r_done) begin
                r_rx_data  <= {r_dc_lat, r_shift};
                r_rx_valid <= 1'b1;
                if (!r_dc_lat) begin
                    r_cmd_valid <= 1'b1;
                    r_cmd_code  <= r_shift;
                    r_pidx      <= '0;
                    r_phase     <= 1'b0;
                    unique case (1'b1)
                        (r_shift == 8'h2A): r_state <= S_CASET;
                        (r_shift == 8'h2B): r_state <= S_RASET;
                        (r_shift == 8'h2C): begin
                            r_state <= S_RAMWR;
                            r_x     <= r_xs;
                            r_y     <= r_ys;
                        end
                        default: r_state <= S_OTHER;
                    endcase
                end else begin
                    if (r_pidx != 3'd4)
                        r_pidx <= r_pidx + 3'd1;
                    unique case (r_state)
                        S_CASET: begin
                            if (r_pidx == 3'd1) r_xs <= r_shift;
                            if (r_pidx == 3'd3) r_xe <= r_shift;
                        end
                        S_RASET: begin
                            if (r_pidx == 3'd1) r_ys <= r_shift;
                            if (r_pidx == 3'd3) r_ye <= r_shift;
                        end
                        S_RAMWR: begin
                            if (!r_phase) begin
                                r_hi    <= r_shift;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase     <= 1'b0;
                                r_pix_valid <= 1'b1;
                                r_pix_color <= {r_hi, r_shift};
                                r_pix_x     <= r_x;
                                r_pix_y     <= r_y;
                                // raster walk inside the window, 8-bit wrap
                                if (r_x == r_xe) begin
                                    r_x <= r_xs;
                                    r_y <= (r_y == r_ye) ? r_ys : r_y + 8'd1;
                                end else begin
                                    r_x <= r_x + 8'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign pix_valid = r_pix_valid;
    assign pix_color = r_pix_color;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign frame_err = r_ferr;

endmodule

// File: tb/tb_st7735_spi_rx.sv
// Bench for st7735_spi_rx: directed scenarios plus randomized bus traffic
// scored against a window/pixel-index model of the display RAM writes.
module tb_st7735_spi_rx;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        spi_cs, spi_dc, spi_sclk, spi_mosi;
    logic [8:0]  rx_data;
    logic        rx_valid, cmd_valid, pix_valid, frame_err;
    logic [7:0]  cmd_code, pix_x, pix_y;
    logic [15:0] pix_color;

    st7735_spi_rx #(.SYNC_STAGES(SYNC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .spi_cs(spi_cs), .spi_dc(spi_dc),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .pix_valid(pix_valid), .pix_color(pix_color),
        .pix_x(pix_x), .pix_y(pix_y), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    logic [8:0]  exp_rx[$], act_rx[$];
    int          act_rxc[$], q_edge[$];
    logic [7:0]  exp_cmd[$], act_cmd[$];
    logic [31:0] exp_pix[$], act_pix[$];
    int exp_ferr = 0, act_ferr = 0, dbl = 0, nosync = 0;
    logic pv_rx = 0, pv_cmd = 0, pv_pix = 0, pv_fe = 0;

    always @(negedge sys_clk) begin
        if (rx_valid) begin
            act_rx.push_back(rx_data);
            act_rxc.push_back(cyc);
        end
        if (cmd_valid) begin
            act_cmd.push_back(cmd_code);
            if (!rx_valid || rx_data[8]) nosync++;
        end
        if (pix_valid) begin
            act_pix.push_back({pix_x, pix_y, pix_color});
            if (!rx_valid || !rx_data[8]) nosync++;
        end
        if (frame_err) act_ferr++;
        if ((rx_valid && pv_rx) || (cmd_valid && pv_cmd) ||
            (pix_valid && pv_pix) || (frame_err && pv_fe)) dbl++;
        pv_rx  = rx_valid;
        pv_cmd = cmd_valid;
        pv_pix = pix_valid;
        pv_fe  = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Display model: window registers plus pixel index since RAMWR
    int         m_cmd, m_pidx, m_k;
    bit         m_pend;
    logic [7:0] m_xs, m_xe, m_ys, m_ye, m_hi;

    task automatic model_reset();
        m_cmd = -1; m_pidx = 0; m_k = 0; m_pend = 0;
        m_xs = 8'd0; m_xe = 8'd127; m_ys = 8'd0; m_ye = 8'd159;
    endtask

    task automatic model_word(input logic dc, input logic [7:0] b);
        logic [7:0] dx, dy, px, py;
        int w, h;
        exp_rx.push_back({dc, b});
        if (!dc) begin
            exp_cmd.push_back(b);
            m_cmd = int'(b); m_pidx = 0; m_pend = 0; m_k = 0;
        end else begin
            if (m_cmd == 'h2A && m_pidx == 1) m_xs = b;
            if (m_cmd == 'h2A && m_pidx == 3) m_xe = b;
            if (m_cmd == 'h2B && m_pidx == 1) m_ys = b;
            if (m_cmd == 'h2B && m_pidx == 3) m_ye = b;
            if (m_cmd == 'h2C) begin
                if (!m_pend) begin
                    m_hi = b; m_pend = 1;
                end else begin
                    m_pend = 0;
                    dx = m_xe - m_xs;
                    dy = m_ye - m_ys;
                    w = int'(dx) + 1;
                    h = int'(dy) + 1;
                    px = 8'(int'(m_xs) + m_k % w);
                    py = 8'(int'(m_ys) + (m_k / w) % h);
                    exp_pix.push_back({px, py, m_hi, b});
                    m_k++;
                end
            end
            m_pidx++;
        end
    endtask

    bit cs_on = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_bits(input logic dc, input logic [7:0] b,
                             input int nb, input int hd);
        for (int i = 0; i < nb; i++) begin
            spi_dc = dc;
            spi_mosi = b[7-i];
            tick(hd);
            spi_sclk = 1'b1;
            if (i == 7) q_edge.push_back(cyc);
            tick(hd);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_lo(input int hd);
        if (!cs_on) begin
            spi_cs = 1'b0; cs_on = 1; tick(hd);
        end
    endtask

    task automatic cs_hi(input int hd);
        if (cs_on) begin
            tick(hd); spi_cs = 1'b1; cs_on = 0; tick(hd + 3);
        end
    endtask

    task automatic put(input logic dc, input logic [7:0] b, input int hd);
        cs_lo(hd);
        send_bits(dc, b, 8, hd);
        model_word(dc, b);
    endtask

    task automatic partial(input int nb, input int hd);
        cs_hi(hd);
        cs_lo(hd);
        send_bits(1'b0, 8'($urandom), nb, hd);
        cs_hi(hd);
        exp_ferr++;
    endtask

    task automatic check_events(input string tag);
        logic [8:0]  a9, e9;
        logic [7:0]  a8, e8;
        logic [31:0] a32, e32;
        int ac, ec;
        chk({tag, " rx count"}, act_rx.size(), exp_rx.size());
        while (act_rx.size() > 0 && exp_rx.size() > 0) begin
            a9 = act_rx.pop_front(); e9 = exp_rx.pop_front();
            ac = act_rxc.pop_front();
            ec = (q_edge.size() > 0) ? q_edge.pop_front() : 0;
            chk({tag, " rx word"}, 32'(a9), 32'(e9));
            chk({tag, " latency"}, ac - ec, LAT);
        end
        chk({tag, " cmd count"}, act_cmd.size(), exp_cmd.size());
        while (act_cmd.size() > 0 && exp_cmd.size() > 0) begin
            a8 = act_cmd.pop_front(); e8 = exp_cmd.pop_front();
            chk({tag, " cmd code"}, 32'(a8), 32'(e8));
        end
        chk({tag, " pix count"}, act_pix.size(), exp_pix.size());
        while (act_pix.size() > 0 && exp_pix.size() > 0) begin
            a32 = act_pix.pop_front(); e32 = exp_pix.pop_front();
            chk({tag, " pix xy/color"}, a32, e32);
        end
        chk({tag, " frame_err count"}, act_ferr, exp_ferr);
        chk({tag, " pulse width"}, dbl, 0);
        chk({tag, " pulse alignment"}, nosync, 0);
        exp_rx = {}; act_rx = {}; act_rxc = {}; q_edge = {};
        exp_cmd = {}; act_cmd = {}; exp_pix = {}; act_pix = {};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " rx_data"}, 32'(rx_data), 0);
        chk({tag, " rx_valid"}, 32'(rx_valid), 0);
        chk({tag, " cmd_valid"}, 32'(cmd_valid), 0);
        chk({tag, " cmd_code"}, 32'(cmd_code), 0);
        chk({tag, " pix_valid"}, 32'(pix_valid), 0);
        chk({tag, " pix_color"}, 32'(pix_color), 0);
        chk({tag, " pix_x"}, 32'(pix_x), 0);
        chk({tag, " pix_y"}, 32'(pix_y), 0);
        chk({tag, " frame_err"}, 32'(frame_err), 0);
    endtask

    logic [8:0] init_seq[$] = '{
        9'h001, 9'h011, 9'h0B1, 9'h101, 9'h12C, 9'h12D,
        9'h0B4, 9'h107, 9'h0C0, 9'h1A2, 9'h102, 9'h184,
        9'h036, 9'h1C8, 9'h03A, 9'h105,
        9'h02A, 9'h100, 9'h100, 9'h100, 9'h17F,
        9'h02B, 9'h100, 9'h100, 9'h100, 9'h19F,
        9'h029, 9'h02C, 9'h1F8, 9'h100, 9'h107, 9'h1E0
    };
    logic [15:0] colors[$] = '{
        16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
        16'h0000, 16'h1234, 16'hABCD
    };

    int hd, np, op;
    logic [7:0]  c;
    logic [15:0] px;

    initial begin
        sys_rst = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0;
        spi_mosi = 1'b0; spi_dc = 1'b0;
        model_reset();
        tick(5);
        chk_zero("reset");
        sys_rst = 1'b0;
        tick(3);
        chk_zero("post-reset");

        // single command byte
        put(1'b0, 8'h2C, 2);
        cs_hi(2);
        tick(8);
        check_events("cmd2C");
        chk("cmd2C cmd_code", 32'(cmd_code), 32'h2C);
        chk("cmd2C rx_data", 32'(rx_data), 32'h02C);

        // window 2..4 x 1..2, seven pixels wrap back to (2,1)
        put(1'b0, 8'h2A, 2);
        put(1'b1, 8'h00, 2); put(1'b1, 8'h02, 2);
        put(1'b1, 8'h00, 2); put(1'b1, 8'h04, 2);
        cs_hi(2);
        put(1'b0, 8'h2B, 3);
        put(1'b1, 8'h00, 3); put(1'b1, 8'h01, 3);
        put(1'b1, 8'h00, 3); put(1'b1, 8'h02, 3);
        cs_hi(3);
        put(1'b0, 8'h2C, 2);
        foreach (colors[i]) begin
            put(1'b1, colors[i][15:8], 2);
            put(1'b1, colors[i][7:0], 2);
            if (i % 2 == 1) cs_hi(2);
        end
        cs_hi(2);
        tick(8);
        check_events("window");
        chk("window last x", 32'(pix_x), 32'd2);
        chk("window last y", 32'(pix_y), 32'd1);

        // truncated byte then a clean data byte
        partial(5, 3);
        put(1'b1, 8'hA5, 3);
        cs_hi(3);
        tick(8);
        check_events("frame_err");
        chk("frame_err rx_data", 32'(rx_data), 32'h1A5);

        // command aborts a half pixel
        put(1'b0, 8'h2C, 2);
        put(1'b1, 8'h12, 2);
        put(1'b0, 8'h29, 2);
        put(1'b1, 8'h55, 2);
        put(1'b1, 8'h66, 2);
        cs_hi(2);
        tick(8);
        check_events("abort");
        chk("abort cmd_code", 32'(cmd_code), 32'h29);

        // reset in the middle of RAMWR and mid-byte
        put(1'b0, 8'h2C, 2);
        for (int i = 0; i < 6; i++) put(1'b1, 8'($urandom), 2);
        tick(8);
        check_events("pre-reset");
        send_bits(1'b1, 8'hF0, 4, 2);
        sys_rst = 1'b1;
        tick(3);
        chk_zero("mid reset");
        sys_rst = 1'b0;
        model_reset();
        tick(3);
        chk_zero("after mid reset");
        cs_hi(2);
        put(1'b1, 8'h11, 2);
        put(1'b1, 8'h22, 2);
        put(1'b0, 8'h2C, 2);
        for (int i = 0; i < 129; i++) begin
            px = 16'($urandom);
            put(1'b1, px[15:8], 2);
            put(1'b1, px[7:0], 2);
        end
        cs_hi(2);
        tick(8);
        check_events("reset-window");
        chk("reset-window last x", 32'(pix_x), 32'd0);
        chk("reset-window last y", 32'(pix_y), 32'd1);

        // init-style sequence at the fastest bus rate
        foreach (init_seq[i]) begin
            put(init_seq[i][8], init_seq[i][7:0], 2);
            cs_hi(2);
        end
        tick(8);
        check_events("init");

        // randomized traffic
        for (int n = 0; n < 70; n++) begin
            hd = $urandom_range(2, 4);
            op = $urandom_range(0, 6);
            if (op == 0 || op == 1) begin
                put(1'b0, (op == 0) ? 8'h2A : 8'h2B, hd);
                np = $urandom_range(0, 5);
                for (int j = 0; j < np; j++) put(1'b1, 8'($urandom), hd);
            end else if (op == 2 || op == 3) begin
                if (op == 2) put(1'b0, 8'h2C, hd);
                np = $urandom_range(0, 9);
                for (int j = 0; j < np; j++) put(1'b1, 8'($urandom), hd);
            end else if (op == 4) begin
                c = 8'($urandom);
                if (c >= 8'h2A && c <= 8'h2C) c = 8'h29;
                put(1'b0, c, hd);
                np = $urandom_range(0, 3);
                for (int j = 0; j < np; j++) put(1'b1, 8'($urandom), hd);
            end else begin
                partial($urandom_range(1, 7), hd);
            end
            if ($urandom_range(0, 2) == 0) cs_hi(hd);
            if (n % 10 == 9) begin
                cs_hi(hd);
                tick(8);
                check_events("random");
            end
        end
        cs_hi(2);
        tick(8);
        check_events("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
